dac_serializer: RTL and testbench
=================================

Name: dac_serializer

Overview:
- Downstream consumer of the DigitalFilter output `yn`: takes the signed 32-bit filtered sample plus a one-cycle valid strobe.
- Offsets, scales and saturates each sample to an unsigned DAC code, then buffers it in a small FIFO.
- Ships each code to an external 12-bit SPI-style DAC as a 16-bit frame (4-bit command + 12-bit data).
- Replaces the file-dump sink in hardware builds.

Parameters:
- OFFSET, 32'h003FFFFF, DC offset added to the signed sample before scaling.
- SHIFT, 11, arithmetic right shift applied after the offset.
- DAC_BITS, 12, DAC code width; the frame is always 16 bits, so DAC_BITS + 4 = 16.
- CMD, 4'b0011, command nibble sent MSB-first ahead of the code.
- CLK_DIV, 2, clk cycles per sclk half-period (>=1).
- GAP_CYCLES, 4, minimum cycles cs_n stays high between frames (>=1).
- FIFO_DEPTH, 4, sample buffer depth (power of two).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- sample_in  in  32  signed filter output `yn`.
- sample_valid  in  1  sample_in valid this cycle.
- enable  in  1  permits new frames to start.
- clr_overflow  in  1  clears overflow and drop_count.
- sclk  out  1  DAC serial clock.
- sdata  out  1  DAC serial data.
- cs_n  out  1  DAC chip select, active low.
- busy  out  1  frame in progress (cs_n low).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries buffered.
- overflow  out  1  sticky: a sample was dropped.
- drop_count  out  16  dropped samples, saturates at 16'hFFFF.

Behaviour:
- Reset (async, immediate): cs_n=1, sclk=0, sdata=0, busy=0, fifo_count=0, overflow=0, drop_count=0. FSM returns to IDLE and FIFO contents are discarded.
- Conversion (stage 1, registered), computed in 34-bit signed arithmetic:
  - s = sample_in + OFFSET; q = s >>> SHIFT.
  - q<0 gives code 0; q>2^DAC_BITS-1 gives code 2^DAC_BITS-1; otherwise code = q[DAC_BITS-1:0].
- FIFO write:
  - Occurs on the edge after stage 1 holds a valid code.
  - Accepted if fifo_count<FIFO_DEPTH, or if the FSM pops in the same cycle.
  - Otherwise the code is dropped: overflow=1 and drop_count increments (saturating).
  - clr_overflow has priority over a simultaneous drop: both flags clear and that drop is not counted.
- Latency, with the FSM idle and the FIFO empty:
  - sample_valid at cycle 0, stage 1 valid at cycle 1, fifo_count=1 at cycle 2.
  - LOAD at cycle 3; cs_n falls at the end of cycle 3, so cs_n=0 from cycle 4.
- FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, GAP.
  - IDLE -> LOAD when enable=1 and fifo_count>0.
  - LOAD: pops the FIFO; frame = {CMD, code}; cs_n=0, sclk=0, sdata=frame[15], bit index=15 -> SHIFT_LO.
  - SHIFT_LO: holds sclk=0 for CLK_DIV cycles -> SHIFT_HI.
  - SHIFT_HI: holds sclk=1 for CLK_DIV cycles; the DAC samples on the rising edge. Then sclk=0.
    - If the bit index is not 0: decrement it, drive the next bit on sdata -> SHIFT_LO.
    - If the bit index is 0: cs_n=1, sdata=0 -> GAP.
  - GAP: holds cs_n=1 for GAP_CYCLES cycles -> IDLE.
- Timing: a frame occupies exactly 32*CLK_DIV cycles with cs_n low; sdata is stable across each rising sclk.
- enable dropping mid-frame does not abort the frame; the current frame and its GAP complete, then the FSM waits in IDLE. The FIFO keeps accepting samples regardless of enable.
- Samples with sample_valid=0 are ignored. Back-to-back valid samples are allowed every cycle.
- busy = ~cs_n.

Decomposition:
- dac_pkg holds:
  - the state enum;
  - FRAME_BITS=16;
  - default CMD;
  - a saturate_code function (offset, shift, clamp) shared with the bench model.
- One sub-module: sample_fifo.
  - Synchronous FIFO with async rst, push/pop/full/empty/count.
  - Holds DAC_BITS-wide entries, depth FIFO_DEPTH.

Test Plan:
- sample_in=0, valid 1 cycle, enable=1, CLK_DIV=2 -> cs_n low from cycle 4 for 64 cycles; the 16 bits captured on sclk rising edges = 16'h37FF (code 2047).
- sample_in=32'h00400000 -> frame 16'h3FFF. sample_in=32'hFFC00000 (s=-1) -> frame 16'h3000.
- sample_in=32'h7FFFFFFF and then 32'h80000000 -> frames 16'h3FFF then 16'h3000, each frame followed by at least GAP_CYCLES=4 of cs_n high.
- 8 consecutive valid samples while enable=0 -> fifo_count=4, overflow=1, drop_count=4. Then enable=1 -> exactly 4 frames in input order. clr_overflow -> overflow=0, drop_count=0.
- Assert rst at cycle 20 of a frame -> cs_n=1, sclk=0, sdata=0, fifo_count=0 in the same cycle (async); no further frames without new samples.
- Deassert enable at bit 8 of a frame -> frame completes all 16 bits; no new cs_n fall while enable=0 even with fifo_count=2.

Source files
------------

// File: rtl/dac_serializer_pkg.sv
// Shared types, frame constants and the sample-to-code conversion.
package dac_pkg;

  localparam int         FRAME_BITS  = 16;
  localparam int         CODE_BITS   = 12;
  localparam logic [3:0] DEFAULT_CMD = 4'b0011;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    GAP
  } state_t;

  // Offset, arithmetic shift and clamp of a signed filter sample into a DAC code.
  // Carried in 34 bits so the offset add can never wrap.
  function automatic logic [CODE_BITS-1:0] saturate_code(
    input logic [31:0] sample,
    input logic [31:0] offset,
    input int          shift,
    input int          dac_bits
  );
    logic signed [33:0] s;
    logic signed [33:0] q;
    logic signed [33:0] max_code;
    s        = $signed({{2{sample[31]}}, sample}) + $signed({{2{offset[31]}}, offset});
    q        = s >>> shift;
    max_code = (34'sd1 <<< dac_bits) - 34'sd1;
    if (q < 34'sd0)
      saturate_code = '0;
    else if (q > max_code)
      saturate_code = max_code[CODE_BITS-1:0];
    else
      saturate_code = q[CODE_BITS-1:0];
  endfunction

endpackage

// File: rtl/dac_serializer_if.sv
// Sample stream in, DAC serial pins and status out.
interface dac_serializer_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   sample_in;
  logic          sample_valid;
  logic          enable;
  logic          clr_overflow;
  logic          sclk;
  logic          sdata;
  logic          cs_n;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic [15:0]   drop_count;

  modport slave (
    input  sample_in, sample_valid, enable, clr_overflow,
    output sclk, sdata, cs_n, busy, fifo_count, overflow, drop_count
  );

  modport master (
    output sample_in, sample_valid, enable, clr_overflow,
    input  sclk, sdata, cs_n, busy, fifo_count, overflow, drop_count
  );
endinterface

// File: rtl/dac_serializer_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
module sample_fifo #(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dac_serializer.sv
// Converts filter samples to DAC codes, buffers them and shifts out 16-bit frames.
//
// state    | meaning
// IDLE     | waiting for enable and a buffered code
// LOAD     | pop a code, build frame, drop cs_n, drive MSB
// SHIFT_LO | sclk low for CLK_DIV cycles
// SHIFT_HI | sclk high for CLK_DIV cycles, DAC samples on the rise
// GAP      | cs_n held high for GAP_CYCLES cycles between frames
module dac_serializer
  import dac_pkg::*;
#(
  parameter logic [31:0] OFFSET     = 32'h003FFFFF,
  parameter int          SHIFT      = 11,
  parameter int          DAC_BITS   = 12,
  parameter logic [3:0]  CMD        = DEFAULT_CMD,
  parameter int          CLK_DIV    = 2,
  parameter int          GAP_CYCLES = 4,
  parameter int          FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  dac_serializer_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(FRAME_BITS);

  logic                  s1_valid;
  logic [CODE_BITS-1:0]  s1_code;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  drop;
  logic [CODE_BITS-1:0]  fifo_dout;
  logic [CW-1:0]         count;

  state_t                state;
  logic [FRAME_BITS-1:0] shreg;
  logic [BW-1:0]         bit_idx;
  logic [15:0]           div_cnt;
  logic [15:0]           gap_cnt;
  logic                  sclk_r;
  logic                  sdata_r;
  logic                  cs_n_r;
  logic                  overflow_r;
  logic [15:0]           drop_r;

  // A full FIFO still accepts a code when the FSM is popping in the same cycle.
  assign pop  = (state == LOAD);
  assign push = s1_valid && (!full || pop);
  assign drop = s1_valid && full && !pop;

  // Stage 1: register the converted code alongside its valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
    end else begin
      s1_valid <= bus.sample_valid;
      s1_code  <= saturate_code(bus.sample_in, OFFSET, SHIFT, DAC_BITS);
    end
  end

  sample_fifo #(
    .WIDTH (CODE_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (s1_code),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Frame sequencer with registered serial outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      div_cnt <= '0;
      gap_cnt <= '0;
      sclk_r  <= 1'b0;
      sdata_r <= 1'b0;
      cs_n_r  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.enable && !empty)
            state <= LOAD;
        end
        LOAD: begin
          shreg   <= {CMD, fifo_dout};
          cs_n_r  <= 1'b0;
          sclk_r  <= 1'b0;
          sdata_r <= CMD[3];
          bit_idx <= BW'(FRAME_BITS - 1);
          div_cnt <= 16'(CLK_DIV - 1);
          state   <= SHIFT_LO;
        end
        SHIFT_LO: begin
          if (div_cnt == '0) begin
            sclk_r  <= 1'b1;
            div_cnt <= 16'(CLK_DIV - 1);
            state   <= SHIFT_HI;
          end else begin
            div_cnt <= div_cnt - 16'd1;
          end
        end
        SHIFT_HI: begin
          if (div_cnt == '0) begin
            sclk_r <= 1'b0;
            if (bit_idx != '0) begin
              bit_idx <= bit_idx - BW'(1);
              sdata_r <= shreg[bit_idx - BW'(1)];
              div_cnt <= 16'(CLK_DIV - 1);
              state   <= SHIFT_LO;
            end else begin
              cs_n_r  <= 1'b1;
              sdata_r <= 1'b0;
              gap_cnt <= 16'(GAP_CYCLES - 1);
              state   <= GAP;
            end
          end else begin
            div_cnt <= div_cnt - 16'd1;
          end
        end
        GAP: begin
          if (gap_cnt == '0)
            state <= IDLE;
          else
            gap_cnt <= gap_cnt - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overflow and saturating drop counter; a clear beats a same-cycle drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
      drop_r     <= '0;
    end else if (bus.clr_overflow) begin
      overflow_r <= 1'b0;
      drop_r     <= '0;
    end else if (drop) begin
      overflow_r <= 1'b1;
      if (drop_r != 16'hFFFF)
        drop_r <= drop_r + 16'd1;
    end
  end

  assign bus.sclk       = sclk_r;
  assign bus.sdata      = sdata_r;
  assign bus.cs_n       = cs_n_r;
  assign bus.busy       = ~cs_n_r;
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow_r;
  assign bus.drop_count = drop_r;

endmodule

// File: tb/tb_dac_serializer.sv
// Self-checking bench for dac_serializer: vector table, corner sequences, random bursts.
module tb_dac_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dac_serializer_if #(.FIFO_DEPTH(4)) bus();

  dac_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] sample;
    logic [15:0] frame;
  } vec_t;

  vec_t        vt[9];
  logic [31:0] burst[8];
  int          rd_idx = 0;

  // Pin monitor: rebuild frames from sclk rises, measure cs_n low time and gaps.
  logic [15:0] fr_q[$];
  int          nb_q[$];
  int          low_q[$];
  logic [15:0] cur = '0;
  int          cur_nb = 0;
  int          low_cnt = 0;
  int          high_run = 0;
  int          gap_min = 1000;
  int          falls = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;
  bit          seen_frame = 1'b0;

  always @(negedge clk) begin
    if (!bus.cs_n) begin
      low_cnt++;
      if (bus.sclk && !prev_sclk) begin
        cur = {cur[14:0], bus.sdata};
        cur_nb++;
      end
      if (prev_cs) begin
        falls++;
        if (seen_frame && high_run < gap_min)
          gap_min = high_run;
      end
    end else begin
      if (!prev_cs) begin
        fr_q.push_back(cur);
        nb_q.push_back(cur_nb);
        low_q.push_back(low_cnt);
        cur_nb     = 0;
        low_cnt    = 0;
        high_run   = 0;
        seen_frame = 1'b1;
      end
      high_run++;
    end
    prev_sclk = bus.sclk;
    prev_cs   = bus.cs_n;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: floor((x + offset) / 2^11) clamped to [0, 4095], behind command 3.
  function automatic logic [15:0] ref_frame(input logic [31:0] x);
    longint s;
    longint q;
    longint code;
    s = longint'($signed(x)) + 64'sd4194303;
    q = s >>> 11;
    if (q < 0)         code = 0;
    else if (q > 4095) code = 4095;
    else               code = q;
    return 16'h3000 | 16'(code);
  endfunction

  function automatic logic [31:0] rand_sample();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1, 2:    return 32'($urandom_range(0, 32'h007FFFFF)) - 32'h00400000;
      default: return 32'h003FF000 + 32'($urandom_range(0, 32'h1FFF));
    endcase
  endfunction

  task automatic send_burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.sample_in    = burst[i];
      bus.sample_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic expect_frame(input string nm, input logic [15:0] exp);
    int t = 0;
    while (fr_q.size() <= rd_idx && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (fr_q.size() <= rd_idx) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      chk(nm, fr_q[rd_idx], exp);
      chk({nm, "_bits"}, nb_q[rd_idx], 16);
      chk({nm, "_lowcyc"}, low_q[rd_idx], 64);
      rd_idx++;
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int f0;
    int k;

    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.enable       = 1'b0;
    bus.clr_overflow = 1'b0;

    vt[0] = '{32'h00000000, 16'h37FF};
    vt[1] = '{32'h00400000, 16'h3FFF};
    vt[2] = '{32'hFFC00000, 16'h3000};
    vt[3] = '{32'h00000800, 16'h3800};
    vt[4] = '{32'hFFFFF800, 16'h37FE};
    vt[5] = '{32'h003FF800, 16'h3FFE};
    vt[6] = '{32'h003FF801, 16'h3FFF};
    vt[7] = '{32'hFFC00001, 16'h3000};
    vt[8] = '{32'h7FFFFFFF, 16'h3FFF};

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_cs_n", bus.cs_n, 1);
    chk("rst_sclk", bus.sclk, 0);
    chk("rst_sdata", bus.sdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_fifo_count", bus.fifo_count, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_drop_count", bus.drop_count, 0);
    rst = 1'b0;
    bus.enable = 1'b1;
    repeat (2) @(posedge clk);

    // Latency from an idle, empty pipeline
    @(posedge clk); #1;
    bus.sample_in    = 32'h0;
    bus.sample_valid = 1'b1;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    chk("lat_c1_cs_n", bus.cs_n, 1);
    @(posedge clk); #1;
    chk("lat_c2_fifo_count", bus.fifo_count, 1);
    chk("lat_c2_cs_n", bus.cs_n, 1);
    @(posedge clk); #1;
    chk("lat_c3_cs_n", bus.cs_n, 1);
    @(posedge clk); #1;
    chk("lat_c4_cs_n", bus.cs_n, 0);
    chk("lat_c4_busy", bus.busy, 1);
    chk("lat_c4_fifo_count", bus.fifo_count, 0);
    expect_frame("lat_frame", 16'h37FF);

    // Vector table, one sample per frame
    for (int i = 0; i < 9; i++) begin
      burst[0] = vt[i].sample;
      send_burst(1);
      expect_frame($sformatf("vec%0d", i), vt[i].frame);
    end

    // Back-to-back extremes
    burst[0] = 32'h7FFFFFFF;
    burst[1] = 32'h80000000;
    send_burst(2);
    expect_frame("b2b_max", 16'h3FFF);
    expect_frame("b2b_min", 16'h3000);

    // Overflow with enable low
    repeat (10) @(posedge clk); #1;
    bus.enable = 1'b0;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 8; i++) burst[i] = rand_sample();
    send_burst(8);
    repeat (3) @(posedge clk); #1;
    chk("ovf_fifo_count", bus.fifo_count, 4);
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_drop_count", bus.drop_count, 4);
    bus.clr_overflow = 1'b1;
    @(posedge clk); #1;
    bus.clr_overflow = 1'b0;
    chk("clr_flag", bus.overflow, 0);
    chk("clr_drop_count", bus.drop_count, 0);

    // Clear in the same cycle as a drop: the drop is not counted
    @(posedge clk); #1;
    bus.sample_in    = rand_sample();
    bus.sample_valid = 1'b1;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    bus.clr_overflow = 1'b1;
    @(posedge clk); #1;
    bus.clr_overflow = 1'b0;
    chk("clr_prio_flag", bus.overflow, 0);
    chk("clr_prio_drop_count", bus.drop_count, 0);

    // A lone drop counts once
    @(posedge clk); #1;
    bus.sample_in    = rand_sample();
    bus.sample_valid = 1'b1;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("drop1_flag", bus.overflow, 1);
    chk("drop1_count", bus.drop_count, 1);
    chk("drop1_fifo_count", bus.fifo_count, 4);

    // Drain: the first four samples in input order
    bus.enable = 1'b1;
    for (int i = 0; i < 4; i++) expect_frame($sformatf("ovf_drain%0d", i), ref_frame(burst[i]));
    bus.clr_overflow = 1'b1;
    @(posedge clk); #1;
    bus.clr_overflow = 1'b0;
    chk("clr2_flag", bus.overflow, 0);
    chk("clr2_drop_count", bus.drop_count, 0);
    repeat (10) @(posedge clk);

    // Async reset at cycle 20 of a frame discards the frame and the FIFO
    for (int i = 0; i < 3; i++) burst[i] = rand_sample();
    send_burst(3);
    t = 0;
    while (bus.cs_n && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("rstmid_frame_started", bus.cs_n, 0);
    repeat (19) @(posedge clk); #2;
    chk("rstmid_pre_fifo_count", bus.fifo_count, 2);
    rst = 1'b1;
    #1;
    chk("rstmid_cs_n", bus.cs_n, 1);
    chk("rstmid_sclk", bus.sclk, 0);
    chk("rstmid_sdata", bus.sdata, 0);
    chk("rstmid_fifo_count", bus.fifo_count, 0);
    chk("rstmid_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rd_idx = fr_q.size();
    f0 = falls;
    repeat (200) @(posedge clk); #1;
    chk("rstmid_no_new_falls", falls, f0);
    chk("rstmid_no_new_frames", fr_q.size(), rd_idx);
    chk("rstmid_fifo_idle", bus.fifo_count, 0);

    // enable dropped at bit 8: the frame finishes, nothing new starts
    for (int i = 0; i < 3; i++) burst[i] = rand_sample();
    send_burst(3);
    t = 0;
    while (cur_nb < 8 && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("endrop_reached_bit8", (cur_nb >= 8) ? 1 : 0, 1);
    bus.enable = 1'b0;
    expect_frame("endrop_frame", ref_frame(burst[0]));
    chk("endrop_fifo_count", bus.fifo_count, 2);
    f0 = falls;
    repeat (200) @(posedge clk); #1;
    chk("endrop_no_new_falls", falls, f0);
    chk("endrop_cs_n_idle", bus.cs_n, 1);
    chk("endrop_fifo_held", bus.fifo_count, 2);
    bus.enable = 1'b1;
    expect_frame("endrop_resume1", ref_frame(burst[1]));
    expect_frame("endrop_resume2", ref_frame(burst[2]));

    // Random bursts against the reference model
    for (int r = 0; r < 15; r++) begin
      k = $urandom_range(1, 4);
      for (int i = 0; i < k; i++) burst[i] = rand_sample();
      send_burst(k);
      for (int i = 0; i < k; i++)
        expect_frame($sformatf("rnd%0d_%0d", r, i), ref_frame(burst[i]));
    end

    repeat (10) @(posedge clk); #1;
    chk("rnd_no_drops", bus.drop_count, 0);
    chk("min_gap_ge4", (gap_min >= 4) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
